// File: rtl/qq_cmd_fe.sv
// Command front end for the quick-queue: buffers {op,kv} requests, issues
// single-cycle enq/deq/repl pulses when the queue is ready, returns removed min.

package pq_pkg;
  typedef struct packed {
    logic [7:0] key;
    logic [7:0] val;
  } kv_t;

  localparam kv_t KV_EMPTY = '{key: 8'hff, val: 8'hff};
endpackage

module qq_cmd_fe
  import pq_pkg::*;
#(
  parameter int unsigned FD  = 4,
  parameter int unsigned GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  kv_t        cmd_kv_i,
  output logic       pq_enq_o,
  output logic       pq_deq_o,
  output logic       pq_repl_o,
  output kv_t        pq_kv_o,
  input  kv_t        pq_min_i,
  input  logic       pq_rdy_i,
  input  logic       pq_full_i,
  input  logic       pq_empty_i,
  output logic       resp_valid_o,
  input  logic       resp_ready_i,
  output kv_t        resp_kv_o,
  output logic       resp_err_o,
  output logic [7:0] drop_cnt_o
);

  localparam int unsigned AW = $clog2(FD);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] OpNop  = 2'd0;
  localparam logic [1:0] OpEnq  = 2'd1;
  localparam logic [1:0] OpDeq  = 2'd2;
  localparam logic [1:0] OpRepl = 2'd3;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StCool  = 2'd2;

  logic [1:0]    op_mem [FD];
  kv_t           kv_mem [FD];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full, fifo_empty, push, pop;
  logic [1:0]    head_op;
  kv_t           head_kv;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] cool_cnt_q, cool_cnt_d;
  kv_t           kv_hold_q;
  logic          resp_valid_q, resp_err_q;
  kv_t           resp_kv_q;
  logic [7:0]    drop_cnt_q;

  logic in_issue, is_enq, is_rm, drop;

  assign fifo_full   = (count_q == (AW + 1)'(FD));
  assign fifo_empty  = (count_q == '0);
  assign cmd_ready_o = !fifo_full && !rst;
  // NOPs are handshaken but never stored.
  assign push        = cmd_valid_i && cmd_ready_o && (cmd_op_i != OpNop);
  assign pop         = in_issue;
  assign head_op     = op_mem[rd_ptr_q];
  assign head_kv     = kv_mem[rd_ptr_q];

  assign in_issue = (state_q == StIssue) && !rst;
  assign is_enq   = (head_op == OpEnq);
  assign is_rm    = (head_op == OpDeq) || (head_op == OpRepl);
  assign drop     = in_issue && ((is_enq && pq_full_i) || (is_rm && pq_empty_i));

  // Legality is judged on the queue flags of the issue cycle itself.
  assign pq_enq_o  = in_issue && is_enq && !pq_full_i;
  assign pq_deq_o  = in_issue && (head_op == OpDeq) && !pq_empty_i;
  assign pq_repl_o = in_issue && (head_op == OpRepl) && !pq_empty_i;
  assign pq_kv_o   = in_issue ? head_kv : kv_hold_q;

  assign resp_valid_o = resp_valid_q;
  assign resp_kv_o    = resp_kv_q;
  assign resp_err_o   = resp_err_q;
  assign drop_cnt_o   = drop_cnt_q;

  // Command storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q] <= cmd_op_i;
      kv_mem[wr_ptr_q] <= cmd_kv_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since FD is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
      else if (!push && pop) count_q <= count_q - (AW + 1)'(1);
    end
  end

  // Next-state: issue only when the queue is ready; removals wait for the response slot.
  always_comb begin
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && pq_rdy_i && (is_enq || !resp_valid_q)) state_d = StIssue;
      end
      StIssue: begin
        state_d    = StCool;
        cool_cnt_d = '0;
      end
      StCool: begin
        if (cool_cnt_q == GW'(GAP - 1)) state_d = StIdle;
        else cool_cnt_d = cool_cnt_q + GW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and cool-down counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cool_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cool_cnt_q <= cool_cnt_d;
    end
  end

  // Queue data output holds the last issued kv between pulses.
  always_ff @(posedge clk) begin
    if (rst)           kv_hold_q <= KV_EMPTY;
    else if (in_issue) kv_hold_q <= head_kv;
  end

  // Response register: loaded on DEQ/REPL issue, held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_kv_q    <= KV_EMPTY;
      resp_err_q   <= 1'b0;
    end else if (in_issue && is_rm) begin
      resp_valid_q <= 1'b1;
      resp_kv_q    <= pq_empty_i ? KV_EMPTY : pq_min_i;
      resp_err_q   <= pq_empty_i;
    end else if (resp_valid_q && resp_ready_i) begin
      resp_valid_q <= 1'b0;
    end
  end

  // Saturating count of rejected operations.
  always_ff @(posedge clk) begin
    if (rst)                             drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 8'hff) drop_cnt_q <= drop_cnt_q + 8'd1;
  end

endmodule

// File: tb/tb_qq_cmd_fe.sv
// Self-checking bench for qq_cmd_fe: behavioural queue model plus pulse/response scoreboard.

module tb_qq_cmd_fe;
  import pq_pkg::*;

  localparam int unsigned FD  = 4;
  localparam int unsigned GAP = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid_i, cmd_ready_o;
  logic [1:0] cmd_op_i;
  kv_t        cmd_kv_i;
  logic       pq_enq_o, pq_deq_o, pq_repl_o;
  kv_t        pq_kv_o, pq_min_i;
  logic       pq_rdy_i, pq_full_i, pq_empty_i;
  logic       resp_valid_o, resp_ready_i, resp_err_o;
  kv_t        resp_kv_o;
  logic [7:0] drop_cnt_o;

  always #5 clk = ~clk;

  qq_cmd_fe #(.FD(FD), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_kv_i(cmd_kv_i),
    .pq_enq_o(pq_enq_o), .pq_deq_o(pq_deq_o), .pq_repl_o(pq_repl_o),
    .pq_kv_o(pq_kv_o), .pq_min_i(pq_min_i), .pq_rdy_i(pq_rdy_i),
    .pq_full_i(pq_full_i), .pq_empty_i(pq_empty_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_kv_o(resp_kv_o), .resp_err_o(resp_err_o), .drop_cnt_o(drop_cnt_o)
  );

  typedef logic [7:0] arr_t [8];
  typedef struct packed { logic [1:0] op; kv_t kv; } pulse_t;
  typedef struct packed { kv_t kv; logic err; } resp_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     last_acc, acc0, exp_drop, resp_valid_cycles;
  bit     ready_low_seen;
  arr_t   pq_keys, sh_keys;
  int     pq_n = 0;
  int     sh_n = 0;
  logic   force_full = 1'b0;
  logic   force_empty = 1'b0;
  pulse_t exp_pulse[$];
  resp_t  exp_resp[$];
  int     pulse_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic kv_t mk(input logic [7:0] k);
    return '{key: k, val: k ^ 8'h5a};
  endfunction

  task automatic ins(inout arr_t a, inout int n, input logic [7:0] k);
    int i;
    i = n;
    while (i > 0 && a[i-1] > k) begin
      a[i] = a[i-1];
      i--;
    end
    a[i] = k;
    n++;
  endtask

  task automatic rm_min(inout arr_t a, inout int n);
    for (int i = 0; i < 7; i++) a[i] = a[i+1];
    if (n > 0) n--;
  endtask

  // Behavioural priority queue seen by the DUT.
  assign pq_full_i  = force_full;
  assign pq_empty_i = force_empty || (pq_n == 0);
  assign pq_min_i   = (pq_n > 0) ? mk(pq_keys[0]) : KV_EMPTY;

  // Monitor: queue model updates just after each edge, observation at negedge.
  initial begin
    logic [1:0] pend, op;
    kv_t        pend_kv;
    pulse_t     ep;
    resp_t      er;
    pend = 2'd0;
    pend_kv = KV_EMPTY;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        if (pend == 2'd1) ins(pq_keys, pq_n, pend_kv.key);
        else if (pend == 2'd2) rm_min(pq_keys, pq_n);
        else if (pend == 2'd3) begin
          rm_min(pq_keys, pq_n);
          ins(pq_keys, pq_n, pend_kv.key);
        end
      end
      pend = 2'd0;
      @(negedge clk);
      if (rst) continue;
      if (!cmd_ready_o) ready_low_seen = 1'b1;
      if (resp_valid_o) resp_valid_cycles++;
      if (pq_enq_o || pq_deq_o || pq_repl_o) begin
        op = pq_enq_o ? 2'd1 : (pq_deq_o ? 2'd2 : 2'd3);
        pulse_cyc.push_back(cyc);
        check_eq("pulse_onehot", 32'($countones({pq_enq_o, pq_deq_o, pq_repl_o})), 32'd1);
        if (exp_pulse.size() == 0) begin
          check_eq("pulse_unexpected", 32'(op), 32'd0);
        end else begin
          ep = exp_pulse.pop_front();
          check_eq("pulse_op", 32'(op), 32'(ep.op));
          check_eq("pulse_kv", 32'(pq_kv_o), 32'(ep.kv));
        end
        pend = op;
        pend_kv = pq_kv_o;
      end
      if (resp_valid_o && resp_ready_i) begin
        if (exp_resp.size() == 0) begin
          check_eq("resp_unexpected", 32'(resp_valid_o), 32'd0);
        end else begin
          er = exp_resp.pop_front();
          check_eq("resp_kv", 32'(resp_kv_o), 32'(er.kv));
          check_eq("resp_err", 32'(resp_err_o), 32'(er.err));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Predict what the DUT will do with a command, from the shadow queue and forced flags.
  task automatic predict(input logic [1:0] op, input logic [7:0] k);
    if (op == 2'd1) begin
      if (force_full) exp_drop++;
      else begin
        exp_pulse.push_back('{2'd1, mk(k)});
        ins(sh_keys, sh_n, k);
      end
    end else if (op != 2'd0) begin
      if (force_empty || sh_n == 0) begin
        exp_drop++;
        exp_resp.push_back('{KV_EMPTY, 1'b1});
      end else begin
        exp_pulse.push_back('{op, mk(k)});
        exp_resp.push_back('{mk(sh_keys[0]), 1'b0});
        rm_min(sh_keys, sh_n);
        if (op == 2'd3) ins(sh_keys, sh_n, k);
      end
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] k, input bit pred);
    bit ok;
    ok = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_kv_i    = mk(k);
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      ok = cmd_ready_o;
    end
    if (!ok) begin
      check_eq("send_timeout", 32'd0, 32'd1);
      cmd_valid_i = 1'b0;
      return;
    end
    last_acc = cyc;
    if (pred) predict(op, k);
    @(posedge clk);
    #2;
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_pulse.size() != 0 || exp_resp.size() != 0) && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) check_eq("drain_timeout", 32'(exp_pulse.size() + exp_resp.size()), 32'd0);
    tick(12);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_eq("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    tick();
    rst = 1'b0;
    exp_pulse.delete();
    exp_resp.delete();
    sh_keys  = pq_keys;
    sh_n     = pq_n;
    exp_drop = 0;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_op_i = 2'd0;
    cmd_kv_i = KV_EMPTY;
    pq_rdy_i = 1'b1;
    resp_ready_i = 1'b1;
    exp_drop = 0;
    resp_valid_cycles = 0;
    ready_low_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pq_keys[i] = 8'h00;
      sh_keys[i] = 8'h00;
    end
    tick(3);
    check_eq("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    check_eq("rst_pulses", 32'({pq_enq_o, pq_deq_o, pq_repl_o}), 32'd0);
    check_eq("rst_pq_kv", 32'(pq_kv_o), 32'(KV_EMPTY));
    check_eq("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check_eq("rst_resp_kv", 32'(resp_kv_o), 32'(KV_EMPTY));
    check_eq("rst_resp_err", 32'(resp_err_o), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt_o), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("ready_after_rst", 32'(cmd_ready_o), 32'd1);

    // 1: back-to-back ENQs, then a NOP that must not reach the queue.
    pulse_cyc.delete();
    ready_low_seen = 1'b0;
    send(2'd1, 8'd5, 1'b1);
    acc0 = last_acc;
    send(2'd1, 8'd3, 1'b1);
    send(2'd1, 8'd9, 1'b1);
    send(2'd0, 8'd77, 1'b1);
    drain();
    check_eq("t1_pulse_count", 32'(pulse_cyc.size()), 32'd3);
    if (pulse_cyc.size() == 3) begin
      check_eq("t1_latency", 32'(pulse_cyc[0] - acc0), 32'd2);
      check_eq("t1_gap01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(2 + GAP));
      check_eq("t1_gap12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'(2 + GAP));
    end
    check_eq("t1_ready_stays", 32'(ready_low_seen), 32'd0);
    check_eq("t1_pq_count", 32'(pq_n), 32'd3);

    // 2: DEQ from {3,5,9}.
    resp_valid_cycles = 0;
    send(2'd2, 8'd0, 1'b1);
    drain();
    check_eq("t2_resp_1cycle", 32'(resp_valid_cycles), 32'd1);
    check_eq("t2_pq_kv_hold", 32'(pq_kv_o), 32'(mk(8'd0)));
    check_eq("t2_drop", 32'(drop_cnt_o), 32'd0);

    // 3: DEQ while queue reports empty.
    force_empty = 1'b1;
    send(2'd2, 8'h11, 1'b1);
    drain();
    force_empty = 1'b0;
    check_eq("t3_drop", 32'(drop_cnt_o), 32'(exp_drop));

    // 4: ENQ while queue reports full, then a legal REPL.
    force_full = 1'b1;
    send(2'd1, 8'h22, 1'b1);
    drain();
    force_full = 1'b0;
    check_eq("t4_drop", 32'(drop_cnt_o), 32'(exp_drop));
    check_eq("t4_pq_kv_hold", 32'(pq_kv_o), 32'(mk(8'h22)));
    send(2'd3, 8'd4, 1'b1);
    drain();
    check_eq("t4_repl_min", 32'(pq_keys[0]), 32'd4);

    // 5: held response blocks only the second DEQ; ENQ passes.
    pq_keys[0] = 8'd1; pq_keys[1] = 8'd2; pq_n = 2;
    sh_keys = pq_keys; sh_n = pq_n;
    resp_ready_i = 1'b0;
    send(2'd2, 8'd0, 1'b1);
    send(2'd1, 8'd7, 1'b1);
    send(2'd2, 8'd0, 1'b1);
    tick(15);
    check_eq("t5_resp_held", 32'(resp_valid_o), 32'd1);
    check_eq("t5_resp_kv_held", 32'(resp_kv_o), 32'(mk(8'd1)));
    check_eq("t5_pending_pulses", 32'(exp_pulse.size()), 32'd1);
    check_eq("t5_pq_count", 32'(pq_n), 32'd2);
    resp_ready_i = 1'b1;
    drain();

    // 6: queue not ready fills the FIFO; reset discards everything.
    pq_keys[0] = 8'd4; pq_n = 1;
    sh_keys = pq_keys; sh_n = pq_n;
    resp_ready_i = 1'b0;
    send(2'd2, 8'd0, 1'b1);
    tick(6);
    check_eq("t6_resp_pending", 32'(resp_valid_o), 32'd1);
    pq_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) send(2'd1, 8'(10 + i), 1'b0);
    check_eq("t6_ready_full", 32'(cmd_ready_o), 32'd0);
    tick(10);
    check_eq("t6_ready_still_full", 32'(cmd_ready_o), 32'd0);
    do_reset();
    check_eq("t6_ready_after_rst", 32'(cmd_ready_o), 32'd1);
    check_eq("t6_resp_cleared", 32'(resp_valid_o), 32'd0);
    check_eq("t6_pq_kv_rst", 32'(pq_kv_o), 32'(KV_EMPTY));
    check_eq("t6_drop_rst", 32'(drop_cnt_o), 32'd0);
    pq_rdy_i = 1'b1;
    resp_ready_i = 1'b1;
    tick(10);
    send(2'd1, 8'd8, 1'b1);
    drain();
    check_eq("end_pulse_q", 32'(exp_pulse.size()), 32'd0);
    check_eq("end_resp_q", 32'(exp_resp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
